ps2_kbd_cmd_ctrl: RTL and testbench

- Command sequencer sitting between the PS/2 host transceiver (tx/rx pair) and the game logic.
- After reset, initialises the keyboard: sends 0xFF, expects 0xFA then BAT 0xAA.
- Afterwards, forwards scan codes and serialises LED-set requests (0xED + value), with ACK, resend and timeout handling.
- The only writer of the transceiver's write-strobe interface.

---
 rtl/ps2_kbd_pkg.sv | 24 ++
 rtl/ps2_kbd_cmd_ctrl_if.sv | 20 ++
 rtl/ps2_kbd_timeout.sv | 26 ++
 rtl/ps2_kbd_cmd_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_ps2_kbd_cmd_ctrl.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_kbd_pkg.sv
// Shared PS/2 keyboard command constants plus the controller state and phase types.
// The phase remembers which byte of a command is currently in flight.
package ps2_kbd_pkg;

  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_SET_LED  = 8'hED;
  localparam logic [7:0] RSP_ACK      = 8'hFA;
  localparam logic [7:0] RSP_RESEND   = 8'hFE;
  localparam logic [7:0] RSP_BAT_OK   = 8'hAA;
  localparam logic [7:0] RSP_BAT_FAIL = 8'hFC;

  typedef enum logic [2:0] {
    ST_SEND, ST_TXWAIT, ST_RSPWAIT, ST_BATWAIT, ST_IDLE, ST_ERROR
  } state_t;

  typedef enum logic [1:0] {
    PH_RST, PH_LEDCMD, PH_LEDVAL
  } phase_t;

  function automatic logic is_busy_state(input state_t s);
    return !((s == ST_IDLE) || (s == ST_ERROR));
  endfunction

endpackage

// File: rtl/ps2_kbd_cmd_ctrl_if.sv
// Byte-level link between the command controller and the PS/2 host transceiver.
// The controller is the master: it owns the write strobe and consumes the status signals.
interface ps2_kbd_cmd_ctrl_if;
  logic       ps2_wr_stb;
  logic [7:0] ps2_wr_data;
  logic       ps2_tx_done;
  logic       ps2_tx_ready;
  logic       ps2_rddata_valid;
  logic [7:0] ps2_rd_data;

  modport master (
    output ps2_wr_stb, ps2_wr_data,
    input  ps2_tx_done, ps2_tx_ready, ps2_rddata_valid, ps2_rd_data
  );

  modport slave (
    input  ps2_wr_stb, ps2_wr_data,
    output ps2_tx_done, ps2_tx_ready, ps2_rddata_valid, ps2_rd_data
  );
endinterface

// File: rtl/ps2_kbd_timeout.sv
// Loadable down-counter that saturates at zero and flags when it is empty.
module ps2_kbd_timeout #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_cnt <= '0;
    else if (i_load)
      r_cnt <= i_load_val;
    else if (i_dec && (r_cnt != '0))
      r_cnt <= r_cnt - W'(1);
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/ps2_kbd_cmd_ctrl.sv
// PS/2 keyboard command sequencer: reset/BAT handshake, LED-set commands with
// resend and timeout recovery, and scan-code forwarding once the keyboard is up.
module ps2_kbd_cmd_ctrl
  import ps2_kbd_pkg::*;
#(
  parameter int RSP_TIMEOUT = 2_500_000,
  parameter int BAT_TIMEOUT = 50_000_000,
  parameter int MAX_RETRY   = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  ps2_kbd_cmd_ctrl_if.master  bus,
  input  logic                i_led_req,
  input  logic [2:0]          i_led_val,
  input  logic                i_restart,
  output logic                o_key_valid,
  output logic [7:0]          o_key_data,
  output logic                o_init_done,
  output logic                o_busy,
  output logic                o_err
);

  localparam int TMAX = (RSP_TIMEOUT > BAT_TIMEOUT) ? RSP_TIMEOUT : BAT_TIMEOUT;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int RW   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [TW-1:0] RSP_LOAD = TW'(RSP_TIMEOUT);
  localparam logic [TW-1:0] BAT_LOAD = TW'(BAT_TIMEOUT);
  localparam logic [RW-1:0] RETRY_LIM = RW'(MAX_RETRY);

  state_t          r_state, w_state_nxt;
  phase_t          r_ph, w_ph_nxt;
  logic [7:0]      r_cur_byte, w_cur_nxt;
  logic [RW-1:0]   r_retry, w_retry_nxt;
  logic            r_led_pend, r_wr_stb, r_key_valid, r_init_done, r_err, r_busy;
  logic [2:0]      r_led_sh;
  logic [7:0]      r_wr_data, r_key_data;
  logic            w_stb_nxt, w_init_nxt, w_err_nxt, w_pend_clr;
  logic            w_tmo_load, w_tmo_dec, w_tmo_zero, w_fwd;
  logic [TW-1:0]   w_tmo_val;

  wire w_rx_ack    = bus.ps2_rddata_valid && (bus.ps2_rd_data == RSP_ACK);
  wire w_rx_resend = bus.ps2_rddata_valid && (bus.ps2_rd_data == RSP_RESEND);

  ps2_kbd_timeout #(.W(TW)) u_timeout (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_tmo_load),
    .i_load_val (w_tmo_val),
    .i_dec      (w_tmo_dec),
    .o_zero     (w_tmo_zero)
  );

  assign w_tmo_dec = (r_state == ST_RSPWAIT) || (r_state == ST_BATWAIT);
  assign w_fwd     = (r_state == ST_IDLE) && bus.ps2_rddata_valid && !i_restart;

  always_comb begin
    w_state_nxt = r_state;
    w_ph_nxt    = r_ph;
    w_cur_nxt   = r_cur_byte;
    w_retry_nxt = r_retry;
    w_stb_nxt   = 1'b0;
    w_init_nxt  = r_init_done;
    w_err_nxt   = r_err;
    w_pend_clr  = 1'b0;
    w_tmo_load  = 1'b0;
    w_tmo_val   = RSP_LOAD;
    case (r_state)
      ST_SEND: begin
        if (bus.ps2_tx_ready) begin
          w_stb_nxt   = 1'b1;
          w_state_nxt = ST_TXWAIT;
        end
      end
      ST_TXWAIT: begin
        if (bus.ps2_tx_done) begin
          w_tmo_load  = 1'b1;
          w_state_nxt = ST_RSPWAIT;
        end
      end
      ST_RSPWAIT: begin
        if (w_rx_ack) begin
          w_retry_nxt = '0;
          case (r_ph)
            PH_RST: begin
              w_tmo_load  = 1'b1;
              w_tmo_val   = BAT_LOAD;
              w_state_nxt = ST_BATWAIT;
            end
            PH_LEDCMD: begin
              w_cur_nxt   = {5'b0, r_led_sh};
              w_ph_nxt    = PH_LEDVAL;
              w_state_nxt = ST_SEND;
            end
            default: w_state_nxt = ST_IDLE;
          endcase
        end else if (w_rx_resend || w_tmo_zero) begin
          // Same byte goes out again; cur_byte is left untouched on purpose
          if (r_retry < RETRY_LIM) begin
            w_retry_nxt = r_retry + RW'(1);
            w_state_nxt = ST_SEND;
          end else begin
            w_state_nxt = ST_ERROR;
            w_err_nxt   = 1'b1;
            w_init_nxt  = 1'b0;
          end
        end
      end
      ST_BATWAIT: begin
        if (bus.ps2_rddata_valid && (bus.ps2_rd_data == RSP_BAT_OK)) begin
          w_state_nxt = ST_IDLE;
          w_init_nxt  = 1'b1;
        end else if ((bus.ps2_rddata_valid && (bus.ps2_rd_data == RSP_BAT_FAIL)) || w_tmo_zero) begin
          w_state_nxt = ST_ERROR;
          w_err_nxt   = 1'b1;
          w_init_nxt  = 1'b0;
        end
      end
      ST_IDLE: begin
        if (r_led_pend) begin
          w_cur_nxt   = CMD_SET_LED;
          w_ph_nxt    = PH_LEDCMD;
          w_pend_clr  = 1'b1;
          w_state_nxt = ST_SEND;
        end
      end
      default: ;
    endcase
    // A restart overrides whatever the state machine decided this cycle
    if (i_restart) begin
      w_state_nxt = ST_SEND;
      w_ph_nxt    = PH_RST;
      w_cur_nxt   = CMD_RESET;
      w_retry_nxt = '0;
      w_stb_nxt   = 1'b0;
      w_init_nxt  = 1'b0;
      w_err_nxt   = 1'b0;
      w_tmo_load  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_SEND;
      r_ph       <= PH_RST;
      r_cur_byte <= CMD_RESET;
      r_retry    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_ph       <= w_ph_nxt;
      r_cur_byte <= w_cur_nxt;
      r_retry    <= w_retry_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_stb    <= 1'b0;
      r_wr_data   <= 8'h00;
      r_key_valid <= 1'b0;
      r_key_data  <= 8'h00;
      r_init_done <= 1'b0;
      r_err       <= 1'b0;
      r_busy      <= 1'b0;
      r_led_pend  <= 1'b0;
      r_led_sh    <= 3'b000;
    end else begin
      r_wr_stb    <= w_stb_nxt;
      if (w_stb_nxt)
        r_wr_data <= r_cur_byte;
      r_key_valid <= w_fwd;
      if (w_fwd)
        r_key_data <= bus.ps2_rd_data;
      r_init_done <= w_init_nxt;
      r_err       <= w_err_nxt;
      r_busy      <= is_busy_state(w_state_nxt);
      // A fresh request re-arms the pending flag even while the previous one is taken
      if (i_restart)
        r_led_pend <= 1'b0;
      else if (i_led_req && (r_state != ST_ERROR)) begin
        r_led_pend <= 1'b1;
        r_led_sh   <= i_led_val;
      end else if (w_pend_clr)
        r_led_pend <= 1'b0;
    end
  end

  assign bus.ps2_wr_stb  = r_wr_stb;
  assign bus.ps2_wr_data = r_wr_data;
  assign o_key_valid     = r_key_valid;
  assign o_key_data      = r_key_data;
  assign o_init_done     = r_init_done;
  assign o_busy          = r_busy;
  assign o_err           = r_err;

endmodule

// File: tb/tb_ps2_kbd_cmd_ctrl.sv
// Directed bench for ps2_kbd_cmd_ctrl: a hand-driven transceiver/keyboard model,
// a table of scan-code vectors and sequences for init, LED, resend, timeout and reset.
module tb_ps2_kbd_cmd_ctrl;
  import ps2_kbd_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ledReq = 1'b0;
  logic [2:0] ledVal = 3'b000;
  logic       restart = 1'b0;
  logic       keyValid;
  logic [7:0] keyData;
  logic       initDone, busy, err;

  int vecCnt = 0;
  int missCnt = 0;
  int keyCnt = 0;
  logic [7:0] stbQ[$];

  ps2_kbd_cmd_ctrl_if bus();

  ps2_kbd_cmd_ctrl #(
    .RSP_TIMEOUT(100),
    .BAT_TIMEOUT(2000),
    .MAX_RETRY(3)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .i_led_req   (ledReq),
    .i_led_val   (ledVal),
    .i_restart   (restart),
    .o_key_valid (keyValid),
    .o_key_data  (keyData),
    .o_init_done (initDone),
    .o_busy      (busy),
    .o_err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rdv;
    logic [7:0] rdData;
    logic       expKv;
    logic [7:0] expKd;
  } vec_t;

  vec_t vecs[5];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecCnt++;
    if (act !== exp) begin
      missCnt++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Strobe and key-pulse capture, sampled just after the active edge
  always @(posedge clk) begin
    logic rdyAtEdge;
    rdyAtEdge = bus.ps2_tx_ready;
    #1;
    if (bus.ps2_wr_stb) begin
      stbQ.push_back(bus.ps2_wr_data);
      checkOutput("strobe_while_ready", {31'b0, rdyAtEdge}, 32'd1);
    end
    if (keyValid)
      keyCnt++;
  end

  task automatic applyStimulus(input vec_t v, input int idx);
    bus.ps2_rddata_valid = v.rdv;
    bus.ps2_rd_data      = v.rdData;
    @(negedge clk);
    checkOutput($sformatf("key_valid[%0d]", idx), {31'b0, keyValid}, {31'b0, v.expKv});
    checkOutput($sformatf("key_data[%0d]", idx), {24'b0, keyData}, {24'b0, v.expKd});
  endtask

  task automatic pulseRx(input logic [7:0] b);
    bus.ps2_rddata_valid = 1'b1;
    bus.ps2_rd_data      = b;
    @(negedge clk);
    bus.ps2_rddata_valid = 1'b0;
  endtask

  task automatic txDone();
    bus.ps2_tx_done = 1'b1;
    @(negedge clk);
    bus.ps2_tx_done = 1'b0;
  endtask

  task automatic ledRequest(input logic [2:0] v);
    ledReq = 1'b1;
    ledVal = v;
    @(negedge clk);
    ledReq = 1'b0;
  endtask

  task automatic pulseRestart();
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
  endtask

  task automatic expectStrobe(input string name, input logic [7:0] exp, input int budget, output int waited);
    int n = 0;
    while ((stbQ.size() == 0) && (n < budget)) begin
      @(negedge clk);
      n++;
    end
    waited = n;
    if (stbQ.size() == 0) begin
      vecCnt++;
      missCnt++;
      $display("[TB] FAIL %s: got no strobe within %0d cycles, want 0x%02h", name, budget, exp);
    end else
      checkOutput(name, {24'b0, stbQ.pop_front()}, {24'b0, exp});
  endtask

  task automatic expectNoStrobe(input string name, input int cycles);
    repeat (cycles) @(negedge clk);
    checkOutput(name, stbQ.size(), 32'd0);
    stbQ.delete();
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_wr_stb"},    {31'b0, bus.ps2_wr_stb}, 32'd0);
    checkOutput({tag, "_wr_data"},   {24'b0, bus.ps2_wr_data}, 32'd0);
    checkOutput({tag, "_key_valid"}, {31'b0, keyValid}, 32'd0);
    checkOutput({tag, "_init_done"}, {31'b0, initDone}, 32'd0);
    checkOutput({tag, "_busy"},      {31'b0, busy}, 32'd0);
    checkOutput({tag, "_err"},       {31'b0, err}, 32'd0);
  endtask

  initial begin
    #500_000;
    $display("[TB] FAIL watchdog: simulation did not finish, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int w;
    vecs[0] = '{1'b1, 8'h1C, 1'b1, 8'h1C};
    vecs[1] = '{1'b0, 8'h55, 1'b0, 8'h1C};
    vecs[2] = '{1'b1, 8'hF0, 1'b1, 8'hF0};
    vecs[3] = '{1'b1, 8'h1C, 1'b1, 8'h1C};
    vecs[4] = '{1'b0, 8'h00, 1'b0, 8'h1C};

    bus.ps2_tx_done      = 1'b0;
    bus.ps2_tx_ready     = 1'b0;
    bus.ps2_rddata_valid = 1'b0;
    bus.ps2_rd_data      = 8'h00;

    // Reset state, then hold tx_ready low to prove nothing is strobed
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    checkOutput("reset_key_data", {24'b0, keyData}, 32'd0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    checkOutput("busy_while_not_ready", {31'b0, busy}, 32'd1);
    expectNoStrobe("no_strobe_not_ready", 1);
    bus.ps2_tx_ready = 1'b1;

    $display("[TB] power-up init");
    expectStrobe("init_ff", CMD_RESET, 10, w);
    txDone();
    repeat (5) @(negedge clk);
    pulseRx(RSP_ACK);
    checkOutput("init_busy_batwait", {31'b0, busy}, 32'd1);
    checkOutput("init_not_done_yet", {31'b0, initDone}, 32'd0);
    repeat (1000) @(negedge clk);
    pulseRx(RSP_BAT_OK);
    checkOutput("init_done", {31'b0, initDone}, 32'd1);
    checkOutput("init_busy", {31'b0, busy}, 32'd0);
    checkOutput("init_err", {31'b0, err}, 32'd0);
    expectNoStrobe("init_single_strobe", 20);
    checkOutput("init_no_keys", keyCnt, 32'd0);

    $display("[TB] LED set 101");
    ledRequest(3'b101);
    expectStrobe("led_ed", CMD_SET_LED, 10, w);
    txDone();
    pulseRx(RSP_ACK);
    expectStrobe("led_val05", 8'h05, 10, w);
    txDone();
    checkOutput("led_busy_before_ack", {31'b0, busy}, 32'd1);
    pulseRx(RSP_ACK);
    checkOutput("led_busy_after_ack", {31'b0, busy}, 32'd0);
    checkOutput("led_no_keys", keyCnt, 32'd0);

    $display("[TB] single resend");
    ledRequest(3'b011);
    expectStrobe("rs_ed1", CMD_SET_LED, 10, w);
    txDone();
    pulseRx(RSP_RESEND);
    expectStrobe("rs_ed2", CMD_SET_LED, 10, w);
    txDone();
    pulseRx(RSP_ACK);
    expectStrobe("rs_val03", 8'h03, 10, w);
    txDone();
    pulseRx(RSP_ACK);
    checkOutput("rs_busy", {31'b0, busy}, 32'd0);
    checkOutput("rs_err", {31'b0, err}, 32'd0);
    expectNoStrobe("rs_no_extra", 20);

    $display("[TB] scan code table");
    keyCnt = 0;
    for (int i = 0; i < 5; i++)
      applyStimulus(vecs[i], i);
    checkOutput("scan_key_count", keyCnt, 32'd3);

    $display("[TB] pending LED coalescing");
    ledRequest(3'b100);
    expectStrobe("pend_ed1", CMD_SET_LED, 10, w);
    txDone();
    pulseRx(RSP_ACK);
    expectStrobe("pend_val04", 8'h04, 10, w);
    ledRequest(3'b001);
    ledRequest(3'b010);
    txDone();
    pulseRx(RSP_ACK);
    expectStrobe("pend_ed2", CMD_SET_LED, 10, w);
    txDone();
    pulseRx(RSP_ACK);
    expectStrobe("pend_val02", 8'h02, 10, w);
    txDone();
    pulseRx(RSP_ACK);
    checkOutput("pend_busy", {31'b0, busy}, 32'd0);
    expectNoStrobe("pend_single_cmd", 50);

    $display("[TB] retry limit");
    ledRequest(3'b111);
    for (int i = 0; i < 4; i++) begin
      expectStrobe($sformatf("lim_ed%0d", i), CMD_SET_LED, 10, w);
      txDone();
      pulseRx(RSP_RESEND);
    end
    checkOutput("lim_err", {31'b0, err}, 32'd1);
    checkOutput("lim_init_done", {31'b0, initDone}, 32'd0);
    checkOutput("lim_busy", {31'b0, busy}, 32'd0);
    ledRequest(3'b110);
    expectNoStrobe("lim_silent", 50);

    $display("[TB] restart and response timeout");
    pulseRestart();
    checkOutput("rst1_err", {31'b0, err}, 32'd0);
    checkOutput("rst1_init_done", {31'b0, initDone}, 32'd0);
    expectStrobe("tmo_ff0", CMD_RESET, 10, w);
    for (int i = 1; i <= 3; i++) begin
      txDone();
      expectStrobe($sformatf("tmo_ff%0d", i), CMD_RESET, 150, w);
      checkOutput($sformatf("tmo_gap%0d", i), {31'b0, (w >= 95 && w <= 110)}, 32'd1);
    end
    txDone();
    repeat (110) @(negedge clk);
    checkOutput("tmo_err", {31'b0, err}, 32'd1);
    expectNoStrobe("tmo_silent", 30);

    $display("[TB] restart and re-init");
    pulseRestart();
    checkOutput("rst2_err", {31'b0, err}, 32'd0);
    expectStrobe("rst2_ff", CMD_RESET, 10, w);
    txDone();
    pulseRx(RSP_ACK);
    repeat (10) @(negedge clk);
    pulseRx(RSP_BAT_OK);
    checkOutput("rst2_init_done", {31'b0, initDone}, 32'd1);

    $display("[TB] async reset mid-command");
    ledRequest(3'b010);
    expectStrobe("ar_ed", CMD_SET_LED, 10, w);
    #2;
    rst_n = 1'b0;
    #1;
    checkAllZero("ar");
    @(negedge clk);
    rst_n = 1'b1;
    expectStrobe("ar_ff", CMD_RESET, 10, w);
    checkOutput("ar_init_done", {31'b0, initDone}, 32'd0);
    checkOutput("ar_busy", {31'b0, busy}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vecCnt, missCnt);
    $finish;
  end

endmodule
